// File: rtl/video_stim_pkg.sv
// Shared state encoding and pixel pattern helper for the video stimulus generator.
package video_stim_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FRONT  = 3'd1;
    localparam logic [2:0] S_LINE   = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_BACK   = 3'd4;
    localparam logic [2:0] S_VBLANK = 3'd5;

    typedef enum logic [2:0] {
        StIdle   = S_IDLE,
        StFront  = S_FRONT,
        StLine   = S_LINE,
        StHblank = S_HBLANK,
        StBack   = S_BACK,
        StVblank = S_VBLANK
    } state_e;

    // Unreduced channel value; callers keep the low DATA_WIDTH bits.
    function automatic logic [31:0] pattern_chan(
        input logic [31:0] pix_idx,
        input logic [31:0] line_idx,
        input logic [31:0] frame_cnt,
        input logic [31:0] chan,
        input logic [31:0] chan_num
    );
        return pix_idx * chan_num + chan + line_idx + frame_cnt;
    endfunction

endpackage

// File: rtl/video_stim_pattern.sv
// Registered pixel word generator: pattern while the line is active, zeros (or a
// one-cycle all-ones error word) during blanking.
module video_stim_pattern
    import video_stim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              lval_next_i,
    input  logic                              blank_err_i,
    input  logic [CNT_WIDTH-1:0]              pix_idx_i,
    input  logic [CNT_WIDTH-1:0]              line_idx_i,
    input  logic [CNT_WIDTH-1:0]              frame_cnt_i,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_data_o
);

    localparam int unsigned WordWidth = DATA_WIDTH * CHANNEL_NUM;

    logic [WordWidth-1:0] pix_d, pix_q;

    always_comb begin
        pix_d = '0;
        if (lval_next_i) begin
            for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
                pix_d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(pattern_chan(
                    32'(pix_idx_i), 32'(line_idx_i), 32'(frame_cnt_i), 32'(k),
                    32'(CHANNEL_NUM)));
            end
        end else if (blank_err_i) begin
            pix_d = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix_data_o = pix_q;

endmodule

// File: rtl/video_stim_gen.sv
// Frame/line timing generator with a deterministic multi-channel pixel pattern.
// Optional blanking-violation injection is compiled in with VIDEO_STIM_ERR_INJ_EN.
module video_stim_gen
    import video_stim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned F2L_CYCLES  = 4,
    parameter int unsigned L2F_CYCLES  = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_enable,
    input  logic [CNT_WIDTH-1:0]              iv_width,
    input  logic [CNT_WIDTH-1:0]              iv_height,
    input  logic [CNT_WIDTH-1:0]              iv_h_blank,
    input  logic [CNT_WIDTH-1:0]              iv_v_blank,
    input  logic                              i_err_inj,
    output logic                              o_fval,
    output logic                              o_lval,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic [CNT_WIDTH-1:0]              ov_frame_cnt,
    output logic                              o_frame_done
);

    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] F2lLast = CNT_WIDTH'(F2L_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] L2fLast = CNT_WIDTH'(L2F_CYCLES - 1);

    function automatic logic [CNT_WIDTH-1:0] clamp1(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? CntOne : v;
    endfunction

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] line_q, line_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] width_q, width_d;
    logic [CNT_WIDTH-1:0] height_q, height_d;
    logic [CNT_WIDTH-1:0] hblank_q, hblank_d;
    logic [CNT_WIDTH-1:0] vblank_q, vblank_d;
    logic                 fval_q, fval_d;
    logic                 lval_q, lval_d;
    logic                 done_q, done_d;
    logic                 load_cfg;
    logic                 blank_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntOne;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        load_cfg    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (i_enable) begin
                    state_d  = StFront;
                    load_cfg = 1'b1;
                end
            end
            StFront: begin
                if (cnt_q == F2lLast) begin
                    state_d = StLine;
                    cnt_d   = '0;
                    line_d  = '0;
                end
            end
            StLine: begin
                if (cnt_q == width_q - CntOne) begin
                    cnt_d   = '0;
                    state_d = (line_q == height_q - CntOne) ? StBack : StHblank;
                end
            end
            StHblank: begin
                if (cnt_q == hblank_q - CntOne) begin
                    state_d = StLine;
                    cnt_d   = '0;
                    line_d  = line_q + CntOne;
                end
            end
            StBack: begin
                if (cnt_q == L2fLast) begin
                    state_d     = StVblank;
                    cnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + CntOne;
                    done_d      = 1'b1;
                end
            end
            StVblank: begin
                if (cnt_q == vblank_q - CntOne) begin
                    cnt_d = '0;
                    if (i_enable) begin
                        state_d  = StFront;
                        load_cfg = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Geometry is frozen for the whole frame once FRONT is entered.
        width_d  = load_cfg ? clamp1(iv_width)   : width_q;
        height_d = load_cfg ? clamp1(iv_height)  : height_q;
        hblank_d = load_cfg ? clamp1(iv_h_blank) : hblank_q;
        vblank_d = load_cfg ? clamp1(iv_v_blank) : vblank_q;

        fval_d = (state_d != StIdle) && (state_d != StVblank);
        lval_d = (state_d == StLine);
    end

`ifdef VIDEO_STIM_ERR_INJ_EN
    logic arm_q, arm_d;

    always_comb begin
        blank_err_d = arm_q && ((state_d == StHblank) || (state_d == StVblank));
        arm_d       = arm_q;
        if (blank_err_d) begin
            arm_d = 1'b0;
        end else if (i_err_inj) begin
            arm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
        end
    end
`else
    logic unused_err_inj;
    assign unused_err_inj = i_err_inj;
    assign blank_err_d    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            line_q      <= '0;
            frame_cnt_q <= '0;
            width_q     <= CntOne;
            height_q    <= CntOne;
            hblank_q    <= CntOne;
            vblank_q    <= CntOne;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            width_q     <= width_d;
            height_q    <= height_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
            done_q      <= done_d;
        end
    end

    video_stim_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNEL_NUM(CHANNEL_NUM),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pattern (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .lval_next_i(lval_d),
        .blank_err_i(blank_err_d),
        .pix_idx_i  (cnt_d),
        .line_idx_i (line_d),
        .frame_cnt_i(frame_cnt_d),
        .pix_data_o (ov_pix_data)
    );

    assign o_fval       = fval_q;
    assign o_lval       = lval_q;
    assign ov_frame_cnt = frame_cnt_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_video_stim_gen.sv
// Self-checking bench for video_stim_gen: timing table, pattern spot checks,
// enable drop, async reset, zero config, randomized geometry vs. a frame model.
module tb_video_stim_gen;

    localparam int DW  = 8;
    localparam int CN  = 4;
    localparam int CW  = 16;
    localparam int F2L = 4;
    localparam int L2F = 4;
`ifdef VIDEO_STIM_ERR_INJ_EN
    localparam int EXP_VIOL = 1;
`else
    localparam int EXP_VIOL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_err_inj = 1'b0;
    logic [CW-1:0] iv_width = '0;
    logic [CW-1:0] iv_height = '0;
    logic [CW-1:0] iv_h_blank = '0;
    logic [CW-1:0] iv_v_blank = '0;
    logic          o_fval, o_lval, o_frame_done;
    logic [DW*CN-1:0] ov_pix_data;
    logic [CW-1:0] ov_frame_cnt;

    video_stim_gen #(
        .DATA_WIDTH (DW),
        .CHANNEL_NUM(CN),
        .CNT_WIDTH  (CW),
        .F2L_CYCLES (F2L),
        .L2F_CYCLES (L2F)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_enable    (i_enable),
        .iv_width    (iv_width),
        .iv_height   (iv_height),
        .iv_h_blank  (iv_h_blank),
        .iv_v_blank  (iv_v_blank),
        .i_err_inj   (i_err_inj),
        .o_fval      (o_fval),
        .o_lval      (o_lval),
        .ov_pix_data (ov_pix_data),
        .ov_frame_cnt(ov_frame_cnt),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        fval;
        logic        lval;
        logic        done;
        logic [15:0] fcnt;
        logic [31:0] pix;
    } exp_t;

    typedef struct {
        int w, h, hb, vb;
        int fval_hi;
        int period;
        int pulses;
    } vec_t;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    int   st_fval_hi, st_lval_rise;
    int   st_done_idx[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic logic [31:0] model_word(input int p, input int l, input int f);
        logic [31:0] w;
        for (int k = 0; k < CN; k++) w[k*DW +: DW] = 8'((p * CN + k + l + f) % 256);
        return w;
    endfunction

    task automatic push(input logic fv, input logic lv, input logic dn, input int fc,
                        input logic [31:0] px);
        exp_t e;
        e.fval = fv;
        e.lval = lv;
        e.done = dn;
        e.fcnt = 16'(fc);
        e.pix  = px;
        exp_q.push_back(e);
    endtask

    // One full frame (fval rise through end of vertical blank) as seen on the outputs.
    task automatic build_frame(input int w0, input int h0, input int hb0, input int vb0,
                               input int f);
        int w, h, hb, vb;
        w  = (w0 == 0) ? 1 : w0;
        h  = (h0 == 0) ? 1 : h0;
        hb = (hb0 == 0) ? 1 : hb0;
        vb = (vb0 == 0) ? 1 : vb0;
        repeat (F2L) push(1'b1, 1'b0, 1'b0, f, '0);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) push(1'b1, 1'b1, 1'b0, f, model_word(p, l, f));
            if (l < h - 1) repeat (hb) push(1'b1, 1'b0, 1'b0, f, '0);
        end
        repeat (L2F) push(1'b1, 1'b0, 1'b0, f, '0);
        for (int v = 0; v < vb; v++) push(1'b0, 1'b0, (v == 0), f + 1, '0);
    endtask

    // Called on the negedge where fval was first seen high.
    task automatic run_model(input string name);
        exp_t e, a;
        int   idx;
        logic prev_l;
        idx = 0;
        prev_l = 1'b0;
        st_fval_hi = 0;
        st_lval_rise = 0;
        st_done_idx.delete();
        while (exp_q.size() > 0) begin
            if (idx > 0) @(negedge clk);
            e = exp_q.pop_front();
            a.fval = o_fval;
            a.lval = o_lval;
            a.done = o_frame_done;
            a.fcnt = ov_frame_cnt;
            a.pix  = ov_pix_data;
            chk($sformatf("%s_cyc%0d", name, idx), 64'(a), 64'(e));
            if (o_fval) st_fval_hi++;
            if (o_lval && !prev_l) st_lval_rise++;
            prev_l = o_lval;
            if (o_frame_done) st_done_idx.push_back(idx);
            idx++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        i_enable = 1'b0;
        i_err_inj = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_cfg(input int w, input int h, input int hb, input int vb);
        iv_width = CW'(w);
        iv_height = CW'(h);
        iv_h_blank = CW'(hb);
        iv_v_blank = CW'(vb);
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (!o_fval && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(o_fval), 64'(1));
    endtask

    task automatic wait_lval(input string name);
        int n;
        n = 0;
        while (!o_lval && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(o_lval), 64'(1));
    endtask

    vec_t vecs[4];

    initial begin
        int d0, d1, n, lows, highs, viol;
        logic prev_l, viol_prev_l;

        vecs[0] = '{w: 4, h: 3, hb: 2, vb: 5, fval_hi: 24, period: 29, pulses: 3};
        vecs[1] = '{w: 0, h: 0, hb: 0, vb: 0, fval_hi: 9, period: 10, pulses: 1};
        vecs[2] = '{w: 1, h: 2, hb: 1, vb: 1, fval_hi: 11, period: 12, pulses: 2};
        vecs[3] = '{w: 5, h: 1, hb: 3, vb: 2, fval_hi: 13, period: 15, pulses: 1};

        // Reset state
        @(negedge clk);
        chk("rst_fval", 64'(o_fval), 64'(0));
        chk("rst_lval", 64'(o_lval), 64'(0));
        chk("rst_pix", 64'(ov_pix_data), 64'(0));
        chk("rst_fcnt", 64'(ov_frame_cnt), 64'(0));
        chk("rst_done", 64'(o_frame_done), 64'(0));
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_fval", 64'(o_fval), 64'(0));

        // Timing table, each entry run for two frames against the model
        for (int i = 0; i < 4; i++) begin
            do_reset();
            set_cfg(vecs[i].w, vecs[i].h, vecs[i].hb, vecs[i].vb);
            i_enable = 1'b1;
            wait_rise($sformatf("vec%0d_rise", i));
            build_frame(vecs[i].w, vecs[i].h, vecs[i].hb, vecs[i].vb, 0);
            build_frame(vecs[i].w, vecs[i].h, vecs[i].hb, vecs[i].vb, 1);
            run_model($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_fval_hi", i), 64'(st_fval_hi), 64'(2 * vecs[i].fval_hi));
            chk($sformatf("vec%0d_lval_pulses", i), 64'(st_lval_rise),
                64'(2 * vecs[i].pulses));
            chk($sformatf("vec%0d_done_cnt", i), 64'(st_done_idx.size()), 64'(2));
            d0 = (st_done_idx.size() > 0) ? st_done_idx[0] : -1;
            d1 = (st_done_idx.size() > 1) ? st_done_idx[1] : -1;
            chk($sformatf("vec%0d_done_pos", i), 64'(d0), 64'(vecs[i].fval_hi));
            chk($sformatf("vec%0d_period", i), 64'(d1 - d0), 64'(vecs[i].period));
        end

        // Pattern spot check: frame 0, line 1, pix 2
        do_reset();
        set_cfg(4, 3, 2, 5);
        i_enable = 1'b1;
        wait_rise("pat_rise");
        repeat (8) @(negedge clk);
        chk("pat_hblank_lval", 64'(o_lval), 64'(0));
        chk("pat_hblank_pix", 64'(ov_pix_data), 64'(0));
        repeat (4) @(negedge clk);
        chk("pat_l1p2_lval", 64'(o_lval), 64'(1));
        chk("pat_l1p2_pix", 64'(ov_pix_data), 64'h0C0B0A09);

        // Enable drop mid-LINE of frame 2
        n = 0;
        while (!(ov_frame_cnt == 2 && o_lval) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drop_reach_f2_line", 64'(o_lval && ov_frame_cnt == 2), 64'(1));
        i_enable = 1'b0;
        n = 0;
        lows = 0;
        while (!o_frame_done && n < 40) begin
            if (!o_fval) lows++;
            @(negedge clk);
            n++;
        end
        chk("drop_done_seen", 64'(o_frame_done), 64'(1));
        chk("drop_no_partial", 64'(lows), 64'(0));
        chk("drop_fcnt", 64'(ov_frame_cnt), 64'(3));
        highs = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_fval) highs++;
        end
        chk("drop_no_more_fval", 64'(highs), 64'(0));
        chk("drop_fcnt_hold", 64'(ov_frame_cnt), 64'(3));
        i_enable = 1'b1;
        @(negedge clk);
        chk("idle_restart_fval", 64'(o_fval), 64'(1));

        // Asynchronous reset during LINE
        wait_lval("rstmid_line");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_fval", 64'(o_fval), 64'(0));
        chk("rstmid_lval", 64'(o_lval), 64'(0));
        chk("rstmid_pix", 64'(ov_pix_data), 64'(0));
        chk("rstmid_fcnt", 64'(ov_frame_cnt), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        wait_rise("rstmid_rise");
        build_frame(4, 3, 2, 5, 0);
        run_model("rstmid");

        // Error-inject pulse during LINE; count blanking violations up to frame end
        do_reset();
        set_cfg(4, 3, 2, 5);
        i_enable = 1'b1;
        wait_lval("inj_line");
        i_err_inj = 1'b1;
        @(negedge clk);
        i_err_inj = 1'b0;
        prev_l = o_lval;
        viol = 0;
        viol_prev_l = 1'b0;
        n = 0;
        while (!o_frame_done && n < 60) begin
            @(negedge clk);
            n++;
            if ((!o_lval || !o_fval) && ov_pix_data != '0) begin
                viol++;
                viol_prev_l = prev_l;
            end
            prev_l = o_lval;
        end
        chk("inj_done_seen", 64'(o_frame_done), 64'(1));
        chk("inj_violations", 64'(viol), 64'(EXP_VIOL));
`ifdef VIDEO_STIM_ERR_INJ_EN
        chk("inj_first_hblank", 64'(viol_prev_l), 64'(1));
`endif

        // Randomized geometry; config changed after latch applies to the next frame only
        for (int it = 0; it < 6; it++) begin
            int a[4];
            int b[4];
            for (int k = 0; k < 4; k++) begin
                a[k] = int'($urandom_range(0, 5));
                b[k] = int'($urandom_range(0, 5));
            end
            do_reset();
            set_cfg(a[0], a[1], a[2], a[3]);
            i_enable = 1'b1;
            wait_rise($sformatf("rand%0d_rise", it));
            set_cfg(b[0], b[1], b[2], b[3]);
            build_frame(a[0], a[1], a[2], a[3], 0);
            build_frame(b[0], b[1], b[2], b[3], 1);
            run_model($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
